// File: rtl/handshake_constant_table.sv
// Constant source: each accepted control token emits one table entry (fixed or round-robin).
// Latency 1 cycle; output register plus skid register sustain one token per cycle.
// Backpressure: up to two tokens buffered; ctrl_ready comes from registered state only.
module handshake_constant_table #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0] TABLE = {18'h20000, 18'h1FFFF, 18'h00001, 18'h3FE23},
    parameter int MODE       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0]      idx;
    logic                  out_v;
    logic [DATA_WIDTH-1:0] out_d;
    logic                  sk_v;
    logic [DATA_WIDTH-1:0] sk_d;
    logic [DATA_WIDTH-1:0] entries [DEPTH];
    logic [DATA_WIDTH-1:0] tok_d;
    logic                  accept;
    logic                  fire;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entries
        assign entries[gi] = TABLE[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign tok_d      = (MODE != 0) ? entries[idx] : entries[0];
    assign ctrl_ready = ~rst & ~sk_v;
    assign accept     = ctrl_valid & ctrl_ready;
    assign fire       = out_v & outs_ready;
    assign outs       = out_d;
    assign outs_valid = out_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            out_v <= 1'b0;
            out_d <= '0;
            sk_v  <= 1'b0;
            sk_d  <= '0;
        end else begin
            if (accept && MODE != 0 && DEPTH > 1) begin
                idx <= (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
            end
            // A full skid implies a full output slot and ctrl_ready low, so no accept here.
            if (sk_v) begin
                if (fire) begin
                    out_d <= sk_d;
                    sk_v  <= 1'b0;
                end
            end else if (!out_v || fire) begin
                if (accept) begin
                    out_v <= 1'b1;
                    out_d <= tok_d;
                end else if (fire) begin
                    out_v <= 1'b0;
                end
            end else if (accept) begin
                sk_v <= 1'b1;
                sk_d <= tok_d;
            end
        end
    end

endmodule

// File: doc/handshake_constant_table.md
# handshake_constant_table

Registered, parametrised constant source for the Dynamatic handshake datapath. Each accepted control token emits one DATA_WIDTH-bit constant from a compile-time table of DEPTH entries. MODE selects a single fixed value or round-robin cycling through the table. A two-entry output buffer (output register plus skid register) breaks the combinational valid/ready path that a plain constant node leaves open, while sustaining one token per cycle.

## Interface
- DATA_WIDTH, 18, width of each constant and of `outs`.
- DEPTH, 4, number of table entries; legal range 1..256.
- TABLE, {18'h20000, 18'h1FFFF, 18'h00001, 18'h3FE23}, packed DEPTH*DATA_WIDTH vector; entry i = TABLE[i*DATA_WIDTH +: DATA_WIDTH].
- MODE, 1, 0 = always emit entry 0; 1 = cycle entries 0,1,..,DEPTH-1,0,...
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- ctrl_valid  in  1  control token offered.
- ctrl_ready  out  1  block can accept a control token.
- outs  out  DATA_WIDTH  constant value; registered.
- outs_valid  out  1  `outs` holds a token; registered.
- outs_ready  in  1  consumer accepts.

## Operation
- State:
  - index register `idx`, width max(1, clog2(DEPTH));
  - output slot (`out_v`, `out_d`);
  - skid slot (`sk_v`, `sk_d`).
- Reset (rst=1 at an edge): `idx`=0, `out_v`=0, `sk_v`=0, `out_d`=0, `sk_d`=0.
  - While rst is high, ctrl_ready=0.
  - Reset mid-operation discards both buffered tokens and rewinds `idx`.
- ctrl_ready = ~rst & ~sk_v. Accept = ctrl_valid & ctrl_ready. Fire = outs_valid & outs_ready.
- Value of an accepted token: TABLE entry `idx` when MODE=1; entry 0 when MODE=0.
- `idx` update:
  - MODE=1: increments on each accept and wraps from DEPTH-1 to 0.
  - MODE=0 or DEPTH=1: `idx` stays 0.
- Buffer transitions, per cycle:
  - Output slot empty or Fire, skid empty: an accepted token loads the output slot. If nothing is accepted, the output slot clears on Fire.
  - Fire with skid full: skid moves to the output slot and the skid clears. Accept is impossible because ctrl_ready=0.
  - Output slot full, no Fire, Accept: the token goes to the skid slot.
  - Output slot full, no Fire, no Accept: hold.
- outs = `out_d`, outs_valid = `out_v`. `outs` is stable while outs_valid=1 and outs_ready=0.
- Tokens leave in acceptance order. None are dropped or duplicated.
- ctrl_valid may drop without having been accepted; nothing is recorded in that case.

## Timing
- Latency is 1 cycle: a token accepted at edge N is presented with outs_valid=1 after edge N.
- Throughput is 1 token/cycle while outs_ready is held at 1.
- ctrl_ready depends only on registered state and rst. There is no combinational path from outs_ready to ctrl_ready.
- Backpressure: with outs_ready=0, at most two tokens are accepted. ctrl_ready drops in the cycle after the skid fills.
- After outs_ready returns to 1:
  - the skid drains in 1 cycle;
  - ctrl_ready rises the cycle after the skid empties.
- Simultaneous Accept and Fire with an empty skid: the new token replaces the output slot and the skid stays empty.
- Index wrap: the token accepted with `idx`=DEPTH-1 is followed by entry 0 on the next accept, with no bubble.

## Test plan
- **Reset values:** hold rst for 3 cycles with ctrl_valid=1 -> ctrl_ready=0, outs_valid=0, outs=0. First deassert edge: ctrl_ready=1, still no output.
- **Streaming:** MODE=1, DEPTH=4, default TABLE, ctrl_valid=1, outs_ready=1 for 6 cycles -> after 1 cycle latency, outs sequence 0x3FE23, 0x00001, 0x1FFFF, 0x20000, 0x3FE23, 0x00001 on consecutive cycles.
- **Backpressure:** outs_ready=0, ctrl_valid=1 -> exactly 2 accepts, ctrl_ready=0 thereafter, outs held at 0x3FE23. Release outs_ready -> 0x00001, then 0x1FFFF, order preserved, no loss.
- **Fixed mode:** MODE=0, 5 tokens with random outs_ready stalls -> every output is 0x3FE23, 5 outputs total.
- **Degenerate and random:** DEPTH=1, MODE=1, random ctrl_valid/outs_ready -> output count equals accept count, all 0x3FE23. Scoreboard reference model matches exactly.
- **Mid-operation reset:** assert rst with both slots full and `idx`=2 -> next edge outs_valid=0. After release, the first output is 0x3FE23 (idx rewound).
